// File: rtl/program_loader.sv
// Boot loader: packs a valid/ready byte stream MSB-first into 32-bit words, writes them to memory
// from address 0 and holds the CPU in reset until the image is in. Option: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned LOAD_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
`ifdef LOADER_CHECKSUM_EN
  output logic              csum_err,
`endif
  output logic [ADDR_W:0]   loaded_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StLoad, StWrite, StRun, StCheck, StError} state_e;
`else
  typedef enum logic [1:0] {StLoad, StWrite, StRun} state_e;
`endif

  localparam logic [ADDR_W:0] LastCount = (ADDR_W+1)'(LOAD_WORDS);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  // Only the first three bytes need holding; the fourth goes straight into the write data.
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              accept;
  logic              clear;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_err_q, csum_err_d;
`endif

  always_comb begin
    accept     = in_valid && in_ready_q;
    clear      = 1'b0;
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      StLoad: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_byte;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {asm_q, in_byte};
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (cnt_d == LastCount) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StRun;
`endif
        end else begin
          state_d = StLoad;
        end
      end
      StRun: begin
        if (reload) clear = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = (in_byte == csum_q) ? StRun : StError;
      end
      StError: begin
        if (reload) clear = 1'b1;
      end
`endif
      default: clear = 1'b1;
    endcase

    if (clear) begin
      state_d    = StLoad;
      byte_cnt_d = '0;
      asm_d      = '0;
      cnt_d      = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end

    // Outputs are decoded from the next state so they line up with state_q.
`ifdef LOADER_CHECKSUM_EN
    in_ready_d  = (state_d == StLoad) || (state_d == StCheck);
    csum_err_d  = (state_d == StError);
`else
    in_ready_d  = (state_d == StLoad);
`endif
    mem_we_d    = (state_d == StWrite);
    cpu_reset_d = (state_d != StRun);
    done_d      = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoad;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
      csum_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_err_q  <= csum_err_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign loaded_count = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum_err     = csum_err_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: three instances share the stimulus, each test checks one.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       reload;
  int         n_checks = 0;
  int         n_fails  = 0;
  int         sel      = 0;

  logic a_in_ready, a_mem_we, a_cpu_reset, a_done;
  logic [6:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [7:0] a_loaded_count;
  logic b_in_ready, b_mem_we, b_cpu_reset, b_done;
  logic [6:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [7:0] b_loaded_count;
`ifdef LOADER_CHECKSUM_EN
  logic a_csum_err, b_csum_err, c_csum_err;
  logic c_in_ready, c_mem_we, c_cpu_reset, c_done;
  logic [6:0] c_mem_addr;
  logic [31:0] c_mem_wdata;
  logic [7:0] c_loaded_count;
`endif

  program_loader #(.ADDR_W(7), .LOAD_WORDS(128)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_ready(a_in_ready),
    .reload(reload), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .cpu_reset(a_cpu_reset), .done(a_done),
`ifdef LOADER_CHECKSUM_EN
    .csum_err(a_csum_err),
`endif
    .loaded_count(a_loaded_count)
  );

  program_loader #(.ADDR_W(7), .LOAD_WORDS(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_ready(b_in_ready),
    .reload(reload), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_reset(b_cpu_reset), .done(b_done),
`ifdef LOADER_CHECKSUM_EN
    .csum_err(b_csum_err),
`endif
    .loaded_count(b_loaded_count)
  );

`ifdef LOADER_CHECKSUM_EN
  program_loader #(.ADDR_W(7), .LOAD_WORDS(2)) u_dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_ready(c_in_ready),
    .reload(reload), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .cpu_reset(c_cpu_reset), .done(c_done), .csum_err(c_csum_err),
    .loaded_count(c_loaded_count)
  );
`endif

  logic ready_sel;
  always_comb begin
    ready_sel = a_in_ready;
    if (sel == 1) ready_sel = b_in_ready;
`ifdef LOADER_CHECKSUM_EN
    if (sel == 2) ready_sel = c_in_ready;
`endif
  end

  // Write monitor, sampled mid-cycle.
  logic [31:0] mem_a [0:127];
  int a_we_cnt  = 0;
  int a_rdy_low = 0;
  int a_rdy_bad = 0;
  int b_we_cnt  = 0;
  always @(negedge clk) begin
    if (a_mem_we === 1'b1) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
      a_we_cnt <= a_we_cnt + 1;
    end
    if (a_cpu_reset === 1'b1 && a_in_ready === 1'b0) a_rdy_low <= a_rdy_low + 1;
    if (a_cpu_reset === 1'b1 && a_in_ready !== !a_mem_we) a_rdy_bad <= a_rdy_bad + 1;
    if (b_mem_we === 1'b1) b_we_cnt <= b_we_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (ready_sel !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk("handshake_ready", ready_sel, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  function automatic logic [31:0] img_word(input int w);
    logic [7:0] v;
    v = 8'(w);
    if (w == 0) return 32'h1004_0000;
    if (w == 64) return 32'h0000_01A4;
    return {v, v ^ 8'h5A, 8'hC3, ~v};
  endfunction

  function automatic logic [7:0] fold(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  logic [31:0] b_img [4] = '{32'hA1B2_C3D4, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5C3};
  int          gaps [16] = '{0, 2, 1, 0, 3, 0, 1, 1, 0, 0, 2, 0, 1, 0, 0, 3};

  task automatic load_b();
    logic [7:0] cs;
    cs = 8'h00;
    for (int w = 0; w < 4; w++) begin
      send_word(b_img[w]);
      cs ^= fold(b_img[w]);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    tick();
`endif
  endtask

  initial begin
    int we0, rl0, rb0, bad;
    logic [7:0] cs;

    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; reload = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and full 128-word image with in_valid held high
    sel = 0;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_mem_we", a_mem_we, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_cpu_reset", a_cpu_reset, 1);
    chk("rst_done", a_done, 0);
    chk("rst_loaded_count", a_loaded_count, 0);
    we0 = a_we_cnt; rl0 = a_rdy_low; rb0 = a_rdy_bad;
    cs = 8'h00;
    for (int w = 0; w < 128; w++) begin
      send_word(img_word(w));
      cs ^= fold(img_word(w));
    end
    chk("last_write_we", a_mem_we, 1);
    chk("last_write_addr", a_mem_addr, 127);
    chk("last_write_cpu_reset", a_cpu_reset, 1);
    chk("last_write_done", a_done, 0);
    tick();
`ifdef LOADER_CHECKSUM_EN
    chk("check_in_ready", a_in_ready, 1);
    chk("check_cpu_reset", a_cpu_reset, 1);
    send_byte(cs);
    chk("a_csum_err", a_csum_err, 0);
`else
    chk("image_csum_unused", {24'h0, cs}, {24'h0, cs ^ 8'h00});
`endif
    chk("run_done", a_done, 1);
    chk("run_cpu_reset", a_cpu_reset, 0);
    chk("run_mem_we", a_mem_we, 0);
    chk("run_loaded_count", a_loaded_count, 128);
    chk("write_pulses", a_we_cnt - we0, 128);
    chk("ready_low_cycles", a_rdy_low - rl0, 128);
    chk("ready_vs_we", a_rdy_bad - rb0, 0);
    chk("word0", mem_a[0], 32'h1004_0000);
    chk("word64", mem_a[64], 32'h0000_01A4);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem_a[i] !== img_word(i)) bad++;
    chk("image_words", bad, 0);

    // Bytes in RUN are ignored; reload restarts at address 0
    we0 = a_we_cnt;
    in_valid = 1'b1; in_byte = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("run_ignore_we", a_we_cnt - we0, 0);
    chk("run_ignore_count", a_loaded_count, 128);
    chk("run_ignore_ready", a_in_ready, 0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_done", a_done, 0);
    chk("reload_cpu_reset", a_cpu_reset, 1);
    chk("reload_in_ready", a_in_ready, 1);
    chk("reload_count", a_loaded_count, 0);
    send_word(32'h1122_3344);
    chk("reload_we", a_mem_we, 1);
    chk("reload_addr", a_mem_addr, 0);
    chk("reload_wdata", a_mem_wdata, 32'h1122_3344);
    tick();
    chk("reload_count1", a_loaded_count, 1);

    // Reset after two bytes of word 5
    for (int w = 1; w < 5; w++) send_word(img_word(w));
    send_byte(8'hAB);
    send_byte(8'hCD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count", a_loaded_count, 0);
    chk("midrst_cpu_reset", a_cpu_reset, 1);
    chk("midrst_we", a_mem_we, 0);
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_word4_kept", mem_a[4], img_word(4));
    send_word(32'hDEAD_BEEF);
    chk("midrst_we_after", a_mem_we, 1);
    chk("midrst_addr", a_mem_addr, 0);
    chk("midrst_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick();

    // LOAD_WORDS=4 with gapped in_valid; idle bytes are garbage
    sel = 1;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("b_rst_in_ready", b_in_ready, 1);
    chk("b_rst_count", b_loaded_count, 0);
    we0 = b_we_cnt;
    cs = 8'h00;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b0;
        in_byte  = 8'hEE;
        repeat (gaps[w*4+k]) tick();
        send_byte(b_img[w][31-8*k -: 8]);
      end
      cs ^= fold(b_img[w]);
      chk("b_we", b_mem_we, 1);
      chk("b_addr", b_mem_addr, w);
      chk("b_wdata", b_mem_wdata, b_img[w]);
      in_byte = 8'hEE;
      tick();
      chk("b_count", b_loaded_count, w + 1);
      chk("b_we_low", b_mem_we, 0);
    end
    chk("b_write_total", b_we_cnt - we0, 4);
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
    chk("b_csum_err", b_csum_err, 0);
`endif
    chk("b_done", b_done, 1);
    chk("b_cpu_reset", b_cpu_reset, 0);

    // Reset with reload on the same edge, then reset on the 4th-byte edge
    reset = 1'b1; tick(); reset = 1'b0;
    load_b();
    chk("b_reload_pre_done", b_done, 1);
    we0 = b_we_cnt;
    reset = 1'b1; reload = 1'b1;
    tick();
    reset = 1'b0; reload = 1'b0;
    chk("rr_count", b_loaded_count, 0);
    chk("rr_cpu_reset", b_cpu_reset, 1);
    chk("rr_done", b_done, 0);
    chk("rr_in_ready", b_in_ready, 1);
    chk("rr_we", b_mem_we, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset = 1'b1; in_valid = 1'b1; in_byte = 8'h44;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("r4_we", b_mem_we, 0);
    chk("r4_count", b_loaded_count, 0);
    chk("r4_in_ready", b_in_ready, 1);
    tick();
    chk("r4_we_next", b_mem_we, 0);
    chk("r4_no_writes", b_we_cnt - we0, 0);
    send_word(32'hCAFE_F00D);
    chk("r4_restart_addr", b_mem_addr, 0);
    chk("r4_restart_wdata", b_mem_wdata, 32'hCAFE_F00D);
    tick();

`ifdef LOADER_CHECKSUM_EN
    // Checksum: bytes 01..08 fold to 0x08
    sel = 2;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h08);
    chk("c_good_done", c_done, 1);
    chk("c_good_err", c_csum_err, 0);
    chk("c_good_cpu_reset", c_cpu_reset, 0);
    chk("c_good_count", c_loaded_count, 2);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("c_reload_ready", c_in_ready, 1);
    chk("c_reload_done", c_done, 0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h09);
    chk("c_bad_err", c_csum_err, 1);
    chk("c_bad_cpu_reset", c_cpu_reset, 1);
    chk("c_bad_done", c_done, 0);
    chk("c_bad_ready", c_in_ready, 0);
    chk("c_bad_we", c_mem_we, 0);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("c_clr_err", c_csum_err, 0);
    chk("c_clr_ready", c_in_ready, 1);
    chk("c_clr_cpu_reset", c_cpu_reset, 1);
    chk("c_clr_addr_data", {c_mem_addr == 7'd1, c_mem_wdata[30:0]}, {1'b1, 31'h0506_0708});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader upstream of the single-cycle CPU's unified instruction/data memory.
- Accepts a byte stream over a valid/ready handshake and packs every 4 bytes into a 32-bit word, MSB first.
- Writes each word to consecutive memory addresses starting at 0.
- Holds the CPU in reset until LOAD_WORDS words have been written.
- Replaces hierarchical memory preloading, so program and data images (e.g. opcodes at 0–63, data at 64–127) arrive through a real port.

Parameters:
- ADDR_W, 7, memory word-address width.
- LOAD_WORDS, 128, number of words per image; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_byte holds a valid byte
- in_byte  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- reload  input  1  single-cycle request to reload the image; honoured only in RUN
- mem_we  output  1  memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  memory write address
- mem_wdata  output  32  memory write data
- cpu_reset  output  1  drives the CPU reset input; high while loading
- done  output  1  image loaded, CPU released
- loaded_count  output  ADDR_W+1  number of words written so far

Behaviour:
- Reset state of all outputs:
  - State = LOAD; byte counter = 0; word counter = 0.
  - in_ready = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - cpu_reset = 1; done = 0; loaded_count = 0.
  - Memory contents are not cleared by the loader.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready.
  - in_byte must hold while in_valid=1 && in_ready=0.
  - in_valid may drop at any time; idle cycles do not advance state.
- Byte packing: accepted bytes shift into a 32-bit assembly register, MSB first.
  - Byte 0 lands in bits [31:24]; byte 3 lands in bits [7:0].
- State LOAD:
  - in_ready = 1.
  - On acceptance of the 4th byte, go to WRITE.
- State WRITE (exactly one cycle):
  - in_ready = 0.
  - mem_we = 1; mem_addr = word counter; mem_wdata = assembled word.
  - At the end of the cycle, the word counter and loaded_count increment.
  - If the new count equals LOAD_WORDS: go to CHECK when CHECKSUM_EN is defined, else go to RUN.
  - Otherwise return to LOAD.
- Throughput: at most 4 words per 20 cycles (4 accept cycles + 1 write cycle per word).
- mem_we is registered and is 0 in every state other than WRITE.
- State RUN:
  - in_ready = 0; done = 1.
  - cpu_reset = 0 from the first cycle in RUN, registered from the state, so the CPU sees reset low one cycle after the final write.
  - Bytes presented in RUN are not accepted.
- Reload: reload=1 in RUN sends the loader to LOAD.
  - Counters clear; loaded_count = 0; done = 0.
  - cpu_reset = 1 from the next cycle.
  - reload is ignored in all other states.
- Reset mid-operation:
  - All counters and the partial assembly register clear; the loader restarts at address 0.
  - Words already written stay in memory.
  - A reset coinciding with reload, or with the 4th-byte acceptance, wins: no write occurs.
- Address wrap: the word counter never exceeds LOAD_WORDS-1 as an address.
  - loaded_count is ADDR_W+1 bits so that LOAD_WORDS = 2**ADDR_W (128) is representable.
- Illegal state encodings recover to LOAD with cpu_reset = 1.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - After the final WRITE, the loader enters CHECK with in_ready = 1.
  - It accepts one extra byte and compares it with the XOR of all 4*LOAD_WORDS image bytes, accumulated at acceptance and cleared on reset/reload.
  - Match: go to RUN.
  - Mismatch: go to ERROR. In ERROR, in_ready = 0, cpu_reset = 1, done = 0, and an extra output csum_err = 1.
  - ERROR is left only by reset or reload; reload is honoured in ERROR as well as RUN.
- When undefined:
  - No CHECK or ERROR state, no accumulator, no csum_err port.
  - The last WRITE goes directly to RUN.

Test Plan:
1. Default params, stream a 128-word image, in_valid held high. Required response:
   - 128 write pulses, addr 0..127, with word 0 = 0x10040000 (bytes 10 04 00 00, a LOAD instruction) and word 64 = 0x000001A4 (420).
   - done = 1 and cpu_reset = 0 one cycle after the last write.
   - in_ready low exactly once per word, in each WRITE cycle.
2. LOAD_WORDS=4, with in_valid toggling in a random pattern and in_byte held while stalled. Required response:
   - mem_wdata sequence equals the packed bytes exactly.
   - loaded_count steps 1,2,3,4.
   - No write on idle cycles.
3. Reset asserted after 2 bytes of word 5. Required response:
   - Next cycle: loaded_count = 0, cpu_reset = 1, no mem_we.
   - The following 4 bytes are written to addr 0.
4. In RUN, present bytes with in_valid=1, then pulse reload. Required response:
   - Bytes are ignored while in RUN.
   - After reload: done = 0, cpu_reset = 1 the next cycle, in_ready = 1; the next image is written from addr 0.
5. Same-edge reset+reload, and reset on the 4th-byte edge. Required response: reset state; mem_we stays 0.
6. LOADER_CHECKSUM_EN, LOAD_WORDS=2, bytes 01 02 03 04 05 06 07 08:
   - Checksum byte 0x08 -> RUN.
   - Checksum byte 0x09 -> csum_err = 1, cpu_reset stays 1; a following reload clears csum_err.
